if_fetch_ctrl: RTL and testbench

IF_FETCH_CTRL -- requirements
Module: if_fetch_ctrl

---
 rtl/if_fetch_ctrl.sv | 116 +++++++++++
 tb/tb_if_fetch_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_ctrl.sv
// Instruction fetch controller: keeps one bus request outstanding, buffers one fetched
// instruction for IF/ID, and squashes in-flight fetches on a jump redirect.
module if_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] INST_NOP = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_addr_i,
    input  logic [2:0]  hold_flag_i,
    output logic        req_o,
    output logic [31:0] req_addr_o,
    input  logic        req_ready_i,
    input  logic        rsp_valid_i,
    input  logic [31:0] rsp_data_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    output logic        inst_valid_o
);

    typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] resp_addr_q;
    logic        req_active_q;
    logic        discard_q;
    logic        jump_pend_q;
    logic [31:0] jump_tgt_q;
    logic        buf_valid_q;
    logic [31:0] buf_inst_q;
    logic [31:0] buf_addr_q;

    logic        consume;
    logic        accept;
    logic        stall;
    logic        rsp_take;
    logic [31:0] jump_tgt;

    always_comb begin
        consume  = buf_valid_q && (hold_flag_i < 3'd2) && !jump_flag_i;
        req_o    = (state_q == StReq) && (req_active_q || !buf_valid_q || consume)
                   && ((hold_flag_i == 3'd0) || req_active_q);
        accept   = req_o && req_ready_i;
        stall    = req_o && !req_ready_i;
        rsp_take = (state_q == StWait) && rsp_valid_i;
        jump_tgt = jump_addr_i & 32'hFFFF_FFFC;
    end

    assign req_addr_o   = pc_q;
    assign inst_o       = buf_valid_q ? buf_inst_q : INST_NOP;
    assign inst_addr_o  = buf_valid_q ? buf_addr_q : 32'd0;
    assign inst_valid_o = buf_valid_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            pc_q         <= RESET_PC;
            resp_addr_q  <= 32'd0;
            req_active_q <= 1'b0;
            discard_q    <= 1'b0;
            jump_pend_q  <= 1'b0;
            jump_tgt_q   <= 32'd0;
            buf_valid_q  <= 1'b0;
            buf_inst_q   <= 32'd0;
            buf_addr_q   <= 32'd0;
        end else begin
            case (state_q)
                StIdle:  state_q <= StReq;
                StReq:   if (accept) state_q <= StWait;
                StWait:  if (rsp_valid_i) state_q <= StReq;
                default: state_q <= StIdle;
            endcase

            if (accept) begin
                req_active_q <= 1'b0;
                resp_addr_q  <= pc_q;
            end else if (stall) begin
                req_active_q <= 1'b1;
            end

            // A jump during a stalled request must not disturb req_addr_o, so the
            // target is parked and applied when the old request is accepted.
            if (jump_flag_i) begin
                if (stall) begin
                    jump_pend_q <= 1'b1;
                    jump_tgt_q  <= jump_tgt;
                end else begin
                    pc_q        <= jump_tgt;
                    jump_pend_q <= 1'b0;
                end
            end else if (accept) begin
                pc_q        <= jump_pend_q ? jump_tgt_q : pc_q + 32'd4;
                jump_pend_q <= 1'b0;
            end

            if (rsp_take) begin
                discard_q <= 1'b0;
            end else if (jump_flag_i && (stall || accept || state_q == StWait)) begin
                discard_q <= 1'b1;
            end

            if (jump_flag_i) begin
                buf_valid_q <= 1'b0;
            end else if (rsp_take && !discard_q) begin
                buf_valid_q <= 1'b1;
                buf_inst_q  <= rsp_data_i;
                buf_addr_q  <= resp_addr_q;
            end else if (consume) begin
                buf_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: zero-wait bus model with a scoreboard of expected
// {addr, data} pairs, plus directed hold / jump / wrap / reset scenarios.
module tb_if_fetch_ctrl;

    localparam logic [31:0] ResetPc = 32'h0000_0000;
    localparam logic [31:0] InstNop = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        jump_flag_i;
    logic [31:0] jump_addr_i;
    logic [2:0]  hold_flag_i;
    logic        req_o;
    logic [31:0] req_addr_o;
    logic        req_ready_i;
    logic        rsp_valid_i;
    logic [31:0] rsp_data_i;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        inst_valid_o;

    if_fetch_ctrl #(
        .RESET_PC (ResetPc),
        .INST_NOP (InstNop)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .jump_flag_i  (jump_flag_i),
        .jump_addr_i  (jump_addr_i),
        .hold_flag_i  (hold_flag_i),
        .req_o        (req_o),
        .req_addr_o   (req_addr_o),
        .req_ready_i  (req_ready_i),
        .rsp_valid_i  (rsp_valid_i),
        .rsp_data_i   (rsp_data_i),
        .inst_o       (inst_o),
        .inst_addr_o  (inst_addr_o),
        .inst_valid_o (inst_valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Reference model of fetch address and in-flight response fate.
    logic [31:0] exp_pc;
    logic [31:0] pend_tgt;
    logic [31:0] out_addr;
    logic [31:0] out_data;
    logic [31:0] last_addr;
    logic [31:0] last_data;
    logic [31:0] rsp_pend_data;
    bit          pend;
    bit          stall_kill;
    bit          out_live;
    bit          out_kill;
    bit          rsp_pend;
    bit          prev_valid;
    int          n_data = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_pc     = ResetPc;
        pend       = 1'b0;
        stall_kill = 1'b0;
        out_live   = 1'b0;
        out_kill   = 1'b0;
        rsp_pend   = 1'b0;
        prev_valid = 1'b0;
    endtask

    // One clock cycle: drive inputs at negedge, sample 1 ns later, update model.
    task automatic step(input logic jmp, input logic [31:0] jaddr, input logic [2:0] hold,
                        input logic rdy);
        logic [31:0] tgt;
        exp_t        e;
        @(negedge clk);
        jump_flag_i = jmp;
        jump_addr_i = jaddr;
        hold_flag_i = hold;
        req_ready_i = rdy;
        rsp_valid_i = rsp_pend;
        rsp_data_i  = rsp_pend_data;
        rsp_pend    = 1'b0;
        tgt         = {jaddr[31:2], 2'b00};
        #1;
        if (inst_valid_o && !prev_valid) begin
            if (exp_q.size() == 0) begin
                check_eq("inst_unexpected", 32'(inst_valid_o), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq("inst_addr", inst_addr_o, e.addr);
                check_eq("inst_data", inst_o, e.data);
            end
        end
        prev_valid = inst_valid_o;
        if (rsp_valid_i && out_live) begin
            if (!out_kill && !jmp) begin
                e.addr = out_addr;
                e.data = out_data;
                exp_q.push_back(e);
                last_addr = out_addr;
                last_data = out_data;
            end
            out_live = 1'b0;
        end
        if (jmp && out_live) out_kill = 1'b1;
        if (req_o && rdy) begin
            check_eq("req_addr", req_addr_o, exp_pc);
            out_live      = 1'b1;
            out_kill      = jmp || stall_kill;
            out_addr      = exp_pc;
            out_data      = 32'hA0 + 32'(n_data);
            n_data++;
            rsp_pend      = 1'b1;
            rsp_pend_data = out_data;
            exp_pc        = jmp ? tgt : (pend ? pend_tgt : exp_pc + 32'd4);
            pend          = 1'b0;
            stall_kill    = 1'b0;
        end else if (jmp) begin
            if (req_o) begin
                stall_kill = 1'b1;
                pend       = 1'b1;
                pend_tgt   = tgt;
            end else begin
                exp_pc = tgt;
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_req"}, 32'(req_o), 32'd0);
        check_eq({tag, "_req_addr"}, req_addr_o, ResetPc);
        check_eq({tag, "_inst"}, inst_o, InstNop);
        check_eq({tag, "_inst_addr"}, inst_addr_o, 32'd0);
        check_eq({tag, "_inst_valid"}, 32'(inst_valid_o), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst         = 1'b0;
        jump_flag_i = 1'b0;
        jump_addr_i = 32'd0;
        hold_flag_i = 3'd0;
        req_ready_i = 1'b1;
        rsp_valid_i = 1'b0;
        rsp_data_i  = 32'd0;
        last_addr   = 32'd0;
        last_data   = 32'd0;
        model_reset();

        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("rst");

        // Release: IDLE this cycle, first request next cycle.
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("idle_req", 32'(req_o), 32'd0);

        // Straight-line fetch: 0x0, 0x4, 0x8 with data A0, A1, A2.
        step(1'b0, 32'd0, 3'd0, 1'b1);
        check_eq("first_req", 32'(req_o), 32'd1);
        repeat (6) step(1'b0, 32'd0, 3'd0, 1'b1);

        // Hold IF with a full buffer: outputs frozen, no new request.
        repeat (2) step(1'b0, 32'd0, 3'd2, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 32'd0, 3'd2, 1'b1);
            check_eq("hold_req", 32'(req_o), 32'd0);
            check_eq("hold_inst_addr", inst_addr_o, last_addr);
            check_eq("hold_inst", inst_o, last_data);
        end
        step(1'b0, 32'd0, 3'd0, 1'b1);
        check_eq("release_req", 32'(req_o), 32'd1);

        // Jump coinciding with the response: response dropped, redirect to 0x1000.
        step(1'b1, 32'h0000_1003, 3'd0, 1'b1);
        step(1'b0, 32'd0, 3'd0, 1'b1);
        check_eq("jrsp_buf", 32'(inst_valid_o), 32'd0);
        check_eq("jrsp_req", 32'(req_o), 32'd1);
        check_eq("jrsp_addr", req_addr_o, 32'h0000_1000);
        step(1'b0, 32'd0, 3'd0, 1'b1);

        // Stalled request under hold ID with a jump pulse: request stays stable.
        step(1'b0, 32'd0, 3'd0, 1'b0);
        check_eq("stall_req", 32'(req_o), 32'd1);
        check_eq("stall_addr", req_addr_o, 32'h0000_1004);
        for (int i = 0; i < 5; i++) begin
            step((i == 2), 32'h0000_2000, 3'd3, 1'b0);
            check_eq("stall_req", 32'(req_o), 32'd1);
            check_eq("stall_addr", req_addr_o, 32'h0000_1004);
        end
        step(1'b0, 32'd0, 3'd3, 1'b1);
        step(1'b0, 32'd0, 3'd3, 1'b1);
        step(1'b0, 32'd0, 3'd0, 1'b1);
        check_eq("jump_req", 32'(req_o), 32'd1);
        check_eq("jump_addr", req_addr_o, 32'h0000_2000);
        step(1'b0, 32'd0, 3'd0, 1'b1);

        // PC wrap from 0xFFFF_FFFC to 0.
        step(1'b1, 32'hFFFF_FFFE, 3'd0, 1'b1);
        step(1'b0, 32'd0, 3'd0, 1'b1);
        step(1'b0, 32'd0, 3'd0, 1'b1);
        step(1'b0, 32'd0, 3'd0, 1'b1);
        check_eq("wrap_addr", req_addr_o, 32'h0000_0000);

        // Reset while WAITing, late response in reset and in IDLE.
        @(negedge clk);
        rst         = 1'b0;
        rsp_valid_i = 1'b1;
        rsp_data_i  = 32'hDEAD_BEEF;
        #1;
        check_reset_outputs("midrst");
        check_eq("midrst_sb", 32'(exp_q.size()), 32'd0);
        model_reset();
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("rerst_idle_req", 32'(req_o), 32'd0);
        check_eq("rerst_idle_valid", 32'(inst_valid_o), 32'd0);
        step(1'b0, 32'd0, 3'd0, 1'b1);
        check_eq("rerst_req", 32'(req_o), 32'd1);
        check_eq("rerst_addr", req_addr_o, ResetPc);
        check_eq("rerst_valid", 32'(inst_valid_o), 32'd0);
        repeat (4) step(1'b0, 32'd0, 3'd0, 1'b1);

        check_eq("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
